// File: rtl/leaf_tx_arbiter.sv
// Round-robin arbiter that feeds one BFT leaf port from NUM_REQ requesters,
// holding each granted packet until the network stops rejecting it.
module leaf_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int P_SZ       = 49,
  parameter int PAYLOAD_SZ = 44
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*P_SZ-1:0]   req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [P_SZ-1:0]           dout_leaf,
  input  logic                      resend,
  output logic                      busy,
  output logic [15:0]               pkt_cnt,
  output logic [15:0]               resend_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [P_SZ-1:0]   hold_q, hold_d;
  logic [15:0]       pkt_cnt_q, pkt_cnt_d;
  logic [15:0]       resend_cnt_q, resend_cnt_d;

  logic [P_SZ-2:0]   slice [NUM_REQ];
  logic [NUM_REQ-1:0] flag_unused;
  logic              load_en;
  logic              gnt_found;
  logic [PTR_W-1:0]  gnt_idx;
  logic [PTR_W:0]    cand;
  logic [PTR_W:0]    ptr_next;

  // The incoming valid flag of each slice is ignored; the stored flag is forced high.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign slice[gi]       = req_data[gi*P_SZ +: P_SZ-1];
    assign flag_unused[gi] = req_data[gi*P_SZ + P_SZ-1];
  end

  assign load_en = (state_q == IDLE) || !resend;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NUM_REQ)) cand = cand - (PTR_W+1)'(NUM_REQ);
      if (!gnt_found && req_valid[cand[PTR_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    ptr_next = {1'b0, gnt_idx} + 1'b1;
    if (ptr_next == (PTR_W+1)'(NUM_REQ)) ptr_next = '0;
  end

  always_comb begin
    req_ready = '0;
    if (load_en && gnt_found && !reset) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    hold_d       = hold_q;
    pkt_cnt_d    = pkt_cnt_q;
    resend_cnt_d = resend_cnt_q;
    if (state_q == SEND) begin
      if (resend) begin
        if (resend_cnt_q != 16'hFFFF) resend_cnt_d = resend_cnt_q + 16'd1;
      end else begin
        pkt_cnt_d = pkt_cnt_q + 16'd1;
      end
    end
    if (load_en) begin
      if (gnt_found) begin
        hold_d  = {1'b1, slice[gnt_idx][P_SZ-2:PAYLOAD_SZ], slice[gnt_idx][PAYLOAD_SZ-1:0]};
        state_d = SEND;
        ptr_d   = ptr_next[PTR_W-1:0];
      end else begin
        hold_d  = '0;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      hold_q       <= '0;
      pkt_cnt_q    <= '0;
      resend_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      hold_q       <= hold_d;
      pkt_cnt_q    <= pkt_cnt_d;
      resend_cnt_q <= resend_cnt_d;
    end
  end

  assign dout_leaf  = hold_q;
  assign busy       = (state_q == SEND);
  assign pkt_cnt    = pkt_cnt_q;
  assign resend_cnt = resend_cnt_q;

endmodule

// File: tb/tb_leaf_tx_arbiter.sv
// Bench for leaf_tx_arbiter: directed scenarios then random traffic, all
// compared against a queue-free behavioural model of the leaf transmitter.
module tb_leaf_tx_arbiter;

  localparam int N  = 4;
  localparam int P  = 49;
  localparam int PL = 44;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N*P-1:0]   req_data = '0;
  logic [N-1:0]     req_ready;
  logic [P-1:0]     dout_leaf;
  logic             resend = 1'b0;
  logic             busy;
  logic [15:0]      pkt_cnt;
  logic [15:0]      resend_cnt;

  int checks = 0;
  int errors = 0;

  // Model: pending packet per requester, the packet on the wire, pointer, counters.
  bit          pend_v [N];
  logic [P-1:0] pend_d [N];
  bit          m_pres_v;
  logic [P-1:0] m_pres;
  int          m_ptr;
  int          m_pkt;
  int          m_rs;

  leaf_tx_arbiter #(.NUM_REQ(N), .P_SZ(P), .PAYLOAD_SZ(PL)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .dout_leaf(dout_leaf), .resend(resend),
    .busy(busy), .pkt_cnt(pkt_cnt), .resend_cnt(resend_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (pend_v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_clear();
    m_pres_v = 0;
    m_pres   = '0;
    m_ptr    = 0;
    m_pkt    = 0;
    m_rs     = 0;
    for (int k = 0; k < N; k++) pend_v[k] = 0;
  endtask

  task automatic add_pkt(input int k, input logic [P-1:0] d);
    pend_v[k] = 1;
    pend_d[k] = d;
  endtask

  // Called just after a falling edge; drives, checks, then advances one cycle.
  task automatic step(input bit rs);
    int g;
    logic [N-1:0] er;
    logic [P-1:0] ed;
    resend = rs;
    for (int k = 0; k < N; k++) begin
      req_valid[k]        = pend_v[k];
      req_data[k*P +: P]  = pend_d[k];
    end
    #1;
    g  = (!m_pres_v || !rs) ? pick() : -1;
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    ed = m_pres_v ? m_pres : '0;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("dout_leaf", 64'(dout_leaf), 64'(ed));
    chk("busy", 64'(busy), 64'(m_pres_v));
    chk("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
    chk("resend_cnt", 64'(resend_cnt), 64'(m_rs));
    $display("t=%0t valid=%b resend=%b ready=%b dout=%h pkt=%0d rs=%0d",
             $time, req_valid, rs, req_ready, dout_leaf, pkt_cnt, resend_cnt);
    @(posedge clk);
    if (m_pres_v && !rs) m_pkt = (m_pkt + 1) & 16'hFFFF;
    if (m_pres_v && rs && m_rs < 16'hFFFF) m_rs++;
    if (!m_pres_v || !rs) begin
      if (g >= 0) begin
        m_pres      = pend_d[g];
        m_pres[P-1] = 1'b1;
        m_pres_v    = 1;
        m_ptr       = (g + 1) % N;
        pend_v[g]   = 0;
      end else begin
        m_pres_v = 0;
      end
    end
    @(negedge clk);
  endtask

  // Reset lands between edges so its effect must be visible before any clock.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_dout", 64'(dout_leaf), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_pkt", 64'(pkt_cnt), 64'd0);
    chk("rst_rscnt", 64'(resend_cnt), 64'd0);
    $display("t=%0t reset asserted", $time);
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    req_valid = '0;
    resend    = 1'b0;
    model_clear();
  endtask

  initial begin
    model_clear();
    for (int k = 0; k < N; k++) pend_d[k] = '0;
    @(negedge clk);
    req_valid = 4'b1111;
    do_reset();

    // Single packet from requester 2, same-cycle grant, next-cycle output.
    add_pkt(2, 49'h0_1234_5678);
    step(0);
    step(0);
    step(0);

    // All requesters busy: strict 0,1,2,3 rotation without bubbles.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < N; k++) if (!pend_v[k]) add_pkt(k, P'({$urandom, $urandom}));
      step(0);
    end
    for (int k = 0; k < N; k++) pend_v[k] = 0;
    step(0);
    step(0);

    // Three rejections then acceptance.
    do_reset();
    add_pkt(1, P'({$urandom, $urandom}));
    step(0);
    step(1); step(1); step(1);
    step(0);
    step(0);

    // Counter saturation and wrap.
    add_pkt(0, P'({$urandom, $urandom}));
    step(0);
    force dut.resend_cnt_q = 16'hFFFE;
    #1;
    release dut.resend_cnt_q;
    m_rs = 16'hFFFE;
    step(1); step(1); step(1);
    force dut.pkt_cnt_q = 16'hFFFF;
    #1;
    release dut.pkt_cnt_q;
    m_pkt = 16'hFFFF;
    step(0);
    step(0);

    // Reset in the middle of a rejection discards the held packet.
    add_pkt(2, P'({$urandom, $urandom}));
    step(0);
    step(1);
    resend = 1'b1;
    do_reset();
    step(0);
    step(0);

    // Rejection while idle is ignored.
    step(1);
    step(1);
    step(0);

    // Random traffic.
    for (int c = 0; c < 300; c++) begin
      for (int k = 0; k < N; k++)
        if (!pend_v[k] && $urandom_range(0, 2) != 0) add_pkt(k, P'({$urandom, $urandom}));
      step($urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/leaf_tx_arbiter.md
LEAF_TX_ARBITER -- requirements
Module: leaf_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters sharing one BFT leaf port (2..8).
REQ-002 The block SHALL have parameter P_SZ, default 49, meaning the leaf packet width; bit P_SZ-1 is the packet-valid flag.
REQ-003 The block SHALL have parameter PAYLOAD_SZ, default 44, meaning payload width; bits [P_SZ-2:PAYLOAD_SZ] carry the destination address.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 The block SHALL have port req_valid, input, NUM_REQ, per-requester packet-available flag.
REQ-007 The block SHALL have port req_data, input, NUM_REQ*P_SZ, with requester i at [i*P_SZ +: P_SZ]; bit P_SZ-1 of each slice is ignored.
REQ-008 The block SHALL have port req_ready, output, NUM_REQ, a one-hot grant/accept strobe.
REQ-009 The block SHALL have port dout_leaf, output, P_SZ, the packet driven into the network leaf.
REQ-010 The block SHALL have port resend, input, 1, the network's same-cycle rejection of the presented packet.
REQ-011 The block SHALL have port busy, output, 1, high while a packet is presented.
REQ-012 The block SHALL have port pkt_cnt, output, 16, a count of accepted packets.
REQ-013 The block SHALL have port resend_cnt, output, 16, a count of rejected presentations.

Function
REQ-014 FSM SHALL have two states: IDLE (nothing presented) and SEND (holding register valid).
REQ-015 Acceptance SHALL be: in SEND at a clock edge with resend=0 -> packet accepted; resend=1 -> rejected, hold.
REQ-016 load_en SHALL equal (IDLE) or (SEND and resend=0), giving back-to-back packets with no bubble.
REQ-017 On load_en with any req_valid set, the arbiter SHALL grant round-robin starting at pointer ptr, searching ptr, ptr+1, ... mod NUM_REQ.
REQ-018 req_ready[g] SHALL be combinational, high only in a cycle where load_en=1 and g is granted; all other bits 0.
REQ-019 Requesters SHALL hold req_valid and req_data stable until req_ready; the block captures req_data slice g on that edge.
REQ-020 The captured packet SHALL be stored with bit P_SZ-1 forced to 1; the state becomes SEND; ptr becomes (g+1) mod NUM_REQ.
REQ-021 On load_en with no req_valid, the state SHALL become IDLE and ptr SHALL be unchanged.
REQ-022 Latency SHALL be: req_ready at cycle t -> packet on dout_leaf at t+1.
REQ-023 dout_leaf SHALL be registered: it equals the holding register in SEND and all-zero in IDLE.
REQ-024 Under resend=1, dout_leaf, state and ptr SHALL be held unchanged, req_ready SHALL be all 0, and rejection SHALL be retried indefinitely.
REQ-025 resend while IDLE SHALL be ignored (no count, no state change).
REQ-026 busy SHALL be high exactly in SEND.
REQ-027 pkt_cnt SHALL increment by 1 per acceptance, wrapping from 0xFFFF to 0x0000.
REQ-028 resend_cnt SHALL increment by 1 per rejection in SEND, saturating at 0xFFFF.
REQ-029 A single requester with continuous req_valid SHALL be served every cycle when the network never rejects.

Reset
REQ-030 While reset is asserted, regardless of clk, the block SHALL force: state IDLE, ptr 0, dout_leaf all-zero, busy 0, req_ready 0, pkt_cnt 0, resend_cnt 0.
REQ-031 A packet held mid-retry when reset asserts SHALL be discarded and SHALL NOT be re-presented after reset.
REQ-032 On the first edge after reset deasserts, the first grant SHALL search from requester 0.

Verification
REQ-033 Reset, then req_valid=4'b0100, data 0x0_1234_5678 -> req_ready=4'b0100 in the same cycle; next cycle dout_leaf bit48=1 with payload 0x12345678; pkt_cnt=1.
REQ-034 All four req_valid held high, resend=0 for 8 cycles -> grant order 0,1,2,3,0,1,2,3 with no idle cycle; pkt_cnt=8.
REQ-035 Packet presented, resend=1 for 3 cycles then 0 -> dout_leaf constant for 4 cycles; req_ready all 0 during rejection; resend_cnt=3; pkt_cnt=1.
REQ-036 Force resend_cnt to 0xFFFE, then apply 3 rejections -> resend_cnt=0xFFFF. Force pkt_cnt to 0xFFFF, then 1 acceptance -> pkt_cnt=0x0000.
REQ-037 Assert reset asynchronously mid-rejection (between clock edges) -> dout_leaf=0 and busy=0 immediately; after release with all req_valid=0, dout_leaf stays 0.
REQ-038 resend=1 while IDLE with no requests -> dout_leaf=0, resend_cnt unchanged at 0.
